// File: rtl/kz_kernel_row_engine_if.sv
// Stream and node-load signals of the kernel row engine.
// The slave side is the engine; the master side is its environment.
interface kz_kernel_row_engine_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_NODES  = 8
);
   localparam int unsigned AW = $clog2(NUM_NODES);

   logic                         node_wr_en;
   logic [AW-1:0]                node_wr_addr;
   logic signed [DATA_WIDTH-1:0] node_wr_x;
   logic signed [DATA_WIDTH-1:0] node_wr_y;
   logic signed [DATA_WIDTH-1:0] node_wr_z;

   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_x;
   logic signed [DATA_WIDTH-1:0] in_y;
   logic signed [DATA_WIDTH-1:0] in_z;

   logic                         out_valid;
   logic                         out_ready;
   logic [31:0]                  out_data;
   logic [AW-1:0]                out_idx;
   logic                         out_last;

   modport master (
      output node_wr_en, node_wr_addr, node_wr_x, node_wr_y, node_wr_z,
      output in_valid, in_x, in_y, in_z,
      input  in_ready,
      input  out_valid, out_data, out_idx, out_last,
      output out_ready
   );

   modport slave (
      input  node_wr_en, node_wr_addr, node_wr_x, node_wr_y, node_wr_z,
      input  in_valid, in_x, in_y, in_z,
      output in_ready,
      output out_valid, out_data, out_idx, out_last,
      input  out_ready
   );
endinterface

// File: rtl/kz_kernel_row_engine.sv
// Streams K(r) = r^3 (Q FRAC_BITS) from one query point to every stored node,
// with L2 distance via a restoring square root or L1 distance via |d| sums.
module kz_kernel_row_engine #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 8,
   parameter int unsigned NUM_NODES  = 8,
   parameter int unsigned DIST_MODE  = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   kz_kernel_row_engine_if.slave   bus,
   output logic                    busy
);
   localparam int unsigned AW      = $clog2(NUM_NODES);
   localparam int unsigned DW1     = DATA_WIDTH + 1;
   localparam int unsigned SW      = 2 * DATA_WIDTH + 4;
   localparam int unsigned RW      = DATA_WIDTH + 2;
   localparam int unsigned RBW     = DATA_WIDTH + 3;
   localparam int unsigned PW      = 2 * RBW;
   localparam int unsigned CW      = PW + RBW;
   localparam int unsigned CNT_W   = $clog2(RW);
   localparam bit          L1_MODE = (DIST_MODE != 0);
   localparam logic [CW-1:0] SAT_LIM = CW'(32'h7FFF_FFFF);

   typedef enum logic [2:0] {
      IDLE,
      DIFF,
      SQRT,
      CUBE1,
      CUBE2,
      OUT
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   accept_c;
   logic   out_hs_c;
   logic   wr_ok_c;

   logic signed [DATA_WIDTH-1:0] node_x [NUM_NODES];
   logic signed [DATA_WIDTH-1:0] node_y [NUM_NODES];
   logic signed [DATA_WIDTH-1:0] node_z [NUM_NODES];

   logic signed [DATA_WIDTH-1:0] q_x;
   logic signed [DATA_WIDTH-1:0] q_y;
   logic signed [DATA_WIDTH-1:0] q_z;
   logic [AW-1:0]                idx;

   logic [SW-1:0]    sq_rad;
   logic [RW-1:0]    sq_rem;
   logic [CNT_W-1:0] sq_cnt;
   logic [RBW-1:0]   r_q;
   logic [PW-1:0]    p_q;

   logic signed [DW1-1:0] dx_c;
   logic signed [DW1-1:0] dy_c;
   logic signed [DW1-1:0] dz_c;
   logic [DW1-1:0]        ax_c;
   logic [DW1-1:0]        ay_c;
   logic [DW1-1:0]        az_c;
   logic [SW-1:0]         s_c;
   logic [RBW-1:0]        l1_c;
   logic [RW+1:0]         rem_sh_c;
   logic [RW+1:0]         trial_c;
   logic                  take_c;
   logic [PW-1:0]         pp_c;
   logic [CW-1:0]         cc_c;
   logic [CW-1:0]         c_c;

   // State register and the registered handshake/status flags derived from it
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.in_ready  <= (state_nxt == IDLE);
         bus.out_valid <= (state_nxt == OUT);
         busy          <= (state_nxt != IDLE);
      end
   end

   // Next-state logic and datapath strobes
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      out_hs_c  = 1'b0;
      wr_ok_c   = 1'b0;
      unique case (state)
         IDLE: begin
            wr_ok_c = bus.node_wr_en && (32'(bus.node_wr_addr) < NUM_NODES);
            if (bus.in_valid && bus.in_ready) begin
               accept_c  = 1'b1;
               state_nxt = DIFF;
            end
         end
         DIFF:  state_nxt = L1_MODE ? CUBE1 : SQRT;
         SQRT:  if (sq_cnt == '0) state_nxt = CUBE1;
         CUBE1: state_nxt = CUBE2;
         CUBE2: state_nxt = OUT;
         OUT: begin
            if (bus.out_ready) begin
               out_hs_c  = 1'b1;
               state_nxt = bus.out_last ? IDLE : DIFF;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Distance, square-root step and cube arithmetic, all floor-truncating
   always_comb begin
      dx_c = DW1'(q_x) - DW1'(node_x[idx]);
      dy_c = DW1'(q_y) - DW1'(node_y[idx]);
      dz_c = DW1'(q_z) - DW1'(node_z[idx]);
      ax_c = dx_c[DW1-1] ? DW1'(-dx_c) : DW1'(dx_c);
      ay_c = dy_c[DW1-1] ? DW1'(-dy_c) : DW1'(dy_c);
      az_c = dz_c[DW1-1] ? DW1'(-dz_c) : DW1'(dz_c);
      s_c  = SW'(ax_c) * SW'(ax_c) + SW'(ay_c) * SW'(ay_c) + SW'(az_c) * SW'(az_c);
      l1_c = RBW'(ax_c) + RBW'(ay_c) + RBW'(az_c);

      // The partial remainder never exceeds RW bits before the final step
      rem_sh_c = {sq_rem, sq_rad[SW-1 -: 2]};
      trial_c  = {r_q[RW-1:0], 2'b01};
      take_c   = (rem_sh_c >= trial_c);

      pp_c = PW'(r_q) * PW'(r_q);
      cc_c = CW'(p_q) * CW'(r_q);
      c_c  = cc_c >> FRAC_BITS;
   end

   // Node memory, query latch and per-state datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_NODES; i++) begin
            node_x[AW'(i)] <= '0;
            node_y[AW'(i)] <= '0;
            node_z[AW'(i)] <= '0;
         end
         q_x          <= '0;
         q_y          <= '0;
         q_z          <= '0;
         idx          <= '0;
         sq_rad       <= '0;
         sq_rem       <= '0;
         sq_cnt       <= '0;
         r_q          <= '0;
         p_q          <= '0;
         bus.out_data <= '0;
         bus.out_idx  <= '0;
         bus.out_last <= 1'b0;
      end else begin
         if (wr_ok_c) begin
            node_x[bus.node_wr_addr] <= bus.node_wr_x;
            node_y[bus.node_wr_addr] <= bus.node_wr_y;
            node_z[bus.node_wr_addr] <= bus.node_wr_z;
         end
         case (state)
            IDLE: begin
               if (accept_c) begin
                  q_x <= bus.in_x;
                  q_y <= bus.in_y;
                  q_z <= bus.in_z;
                  idx <= '0;
               end
            end
            DIFF: begin
               if (L1_MODE) begin
                  r_q <= l1_c;
               end else begin
                  sq_rad <= s_c;
                  sq_rem <= '0;
                  r_q    <= '0;
                  sq_cnt <= CNT_W'(RW - 1);
               end
            end
            SQRT: begin
               sq_rad <= sq_rad << 2;
               sq_rem <= take_c ? RW'(rem_sh_c - trial_c) : RW'(rem_sh_c);
               r_q    <= {r_q[RBW-2:0], take_c};
               sq_cnt <= sq_cnt - CNT_W'(1);
            end
            CUBE1: p_q <= pp_c >> FRAC_BITS;
            CUBE2: begin
               bus.out_data <= (c_c > SAT_LIM) ? 32'h7FFF_FFFF : 32'(c_c);
               bus.out_idx  <= idx;
               bus.out_last <= (32'(idx) == NUM_NODES - 1);
            end
            OUT: begin
               if (out_hs_c && !bus.out_last) idx <= idx + AW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_kz_kernel_row_engine.sv
// Scoreboard bench for kz_kernel_row_engine: an L2 instance exercised over
// several rows (backpressure, saturation, mid-row reset) and an L1 instance.
`timescale 1ns/1ps
module tb_kz_kernel_row_engine;
   localparam int unsigned DW = 16;
   localparam int unsigned F  = 8;
   localparam int unsigned NN = 8;

   typedef struct {
      logic [31:0] data;
      int          idx;
      bit          last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic busy2;
   logic busy1;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   int   mem_x[NN];
   int   mem_y[NN];
   int   mem_z[NN];

   int tx[NN] = '{256, -1000, 5000, -32768, 32767, 100, -7, 768};
   int ty[NN] = '{-512, 2000, 5000, -32768, 0, 200, 13, 1024};
   int tz[NN] = '{128, -3000, 5000, -32768, -32768, 300, 0, 0};

   kz_kernel_row_engine_if #(.DATA_WIDTH(DW), .NUM_NODES(NN)) bus2 ();
   kz_kernel_row_engine_if #(.DATA_WIDTH(DW), .NUM_NODES(NN)) bus1 ();

   kz_kernel_row_engine #(
      .DATA_WIDTH(DW), .FRAC_BITS(F), .NUM_NODES(NN), .DIST_MODE(0)
   ) dut_l2 (
      .clk(clk), .rst(rst), .bus(bus2), .busy(busy2)
   );

   kz_kernel_row_engine #(
      .DATA_WIDTH(DW), .FRAC_BITS(F), .NUM_NODES(NN), .DIST_MODE(1)
   ) dut_l1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1)
   );

   always #5 clk = ~clk;

   function automatic longint unsigned isqrt(input longint unsigned s);
      longint unsigned lo = 0;
      longint unsigned hi = 64'd4194304;
      longint unsigned mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) >> 1;
         if (mid * mid <= s) lo = mid;
         else hi = mid - 1;
      end
      return lo;
   endfunction

   function automatic logic [31:0] model_k(input int qx, input int qy, input int qz,
                                           input int nx, input int ny, input int nz,
                                           input bit l1);
      longint ax = (qx - nx < 0) ? -(qx - nx) : (qx - nx);
      longint ay = (qy - ny < 0) ? -(qy - ny) : (qy - ny);
      longint az = (qz - nz < 0) ? -(qz - nz) : (qz - nz);
      longint unsigned r;
      longint unsigned p;
      longint unsigned c;
      if (l1) r = $unsigned(ax + ay + az);
      else    r = isqrt($unsigned(ax * ax + ay * ay + az * az));
      p = (r * r) >> F;
      c = (p * r) >> F;
      return (c > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : c[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic write_node(input int a, input int x, input int y, input int z);
      bus2.node_wr_en   = 1'b1;
      bus2.node_wr_addr = 3'(a);
      bus2.node_wr_x    = 16'(x);
      bus2.node_wr_y    = 16'(y);
      bus2.node_wr_z    = 16'(z);
      @(negedge clk);
      bus2.node_wr_en = 1'b0;
      mem_x[a] = x;
      mem_y[a] = y;
      mem_z[a] = z;
   endtask

   // Drives one query (optionally with a node write on the same edge) and queues the row
   task automatic start_query(input int qx, input int qy, input int qz, input bit wr,
                              input int wa, input int wx, input int wy, input int wz);
      check("in_ready_before_query", bus2.in_ready, 1);
      if (wr) begin
         bus2.node_wr_en   = 1'b1;
         bus2.node_wr_addr = 3'(wa);
         bus2.node_wr_x    = 16'(wx);
         bus2.node_wr_y    = 16'(wy);
         bus2.node_wr_z    = 16'(wz);
         mem_x[wa] = wx;
         mem_y[wa] = wy;
         mem_z[wa] = wz;
      end
      for (int n = 0; n < NN; n++)
         sb.push_back('{data: model_k(qx, qy, qz, mem_x[n], mem_y[n], mem_z[n], 1'b0),
                        idx: n, last: (n == NN - 1)});
      bus2.in_x     = 16'(qx);
      bus2.in_y     = 16'(qy);
      bus2.in_z     = 16'(qz);
      bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid   = 1'b0;
      bus2.node_wr_en = 1'b0;
   endtask

   // Pops and compares up to count samples; sample stall_n is held off for 10 cycles
   task automatic collect(input int count, input int stall_n, output int first_lat);
      int   cyc;
      exp_t e;
      first_lat = -1;
      for (int n = 0; n < count; n++) begin
         cyc = 0;
         bus2.out_ready = (n == stall_n) ? 1'b0 : 1'b1;
         while (!bus2.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
         if (n == 0) first_lat = cyc;
         if (!bus2.out_valid) begin
            check("out_valid_timeout", bus2.out_valid, 1);
            return;
         end
         e = sb.pop_front();
         check($sformatf("data_n%0d", n), bus2.out_data, e.data);
         check($sformatf("idx_n%0d", n), bus2.out_idx, e.idx);
         check($sformatf("last_n%0d", n), bus2.out_last, e.last);
         if (n == stall_n) begin
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               check("stall_valid", bus2.out_valid, 1);
               check("stall_data", bus2.out_data, e.data);
               check("stall_idx", bus2.out_idx, e.idx);
            end
            bus2.out_ready = 1'b1;
         end
         @(negedge clk);
         check("valid_low_after_hs", bus2.out_valid, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cyc;
      rst = 1'b1;
      bus2.node_wr_en = 1'b0; bus2.node_wr_addr = '0;
      bus2.node_wr_x = '0; bus2.node_wr_y = '0; bus2.node_wr_z = '0;
      bus2.in_valid = 1'b0; bus2.in_x = '0; bus2.in_y = '0; bus2.in_z = '0;
      bus2.out_ready = 1'b1;
      bus1.node_wr_en = 1'b0; bus1.node_wr_addr = '0;
      bus1.node_wr_x = '0; bus1.node_wr_y = '0; bus1.node_wr_z = '0;
      bus1.in_valid = 1'b0; bus1.in_x = '0; bus1.in_y = '0; bus1.in_z = '0;
      bus1.out_ready = 1'b1;
      for (int i = 0; i < NN; i++) begin
         mem_x[i] = 0; mem_y[i] = 0; mem_z[i] = 0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_in_ready", bus2.in_ready, 1);
      check("rst_out_valid", bus2.out_valid, 0);
      check("rst_out_data", bus2.out_data, 0);
      check("rst_out_idx", bus2.out_idx, 0);
      check("rst_out_last", bus2.out_last, 0);
      check("rst_busy", busy2, 0);

      // L2 (3,4,0) against zero nodes: 125.0 everywhere, 21-cycle latency
      start_query(768, 1024, 0, 1'b0, 0, 0, 0, 0);
      check("l2_first_busy", busy2, 1);
      collect(NN, -1, lat);
      check("l2_latency", lat, 21);
      check("row1_in_ready", bus2.in_ready, 1);
      check("row1_busy", busy2, 0);

      // L1 instance: 343.0 everywhere, 3-cycle latency
      bus1.in_x = 16'(768); bus1.in_y = 16'(1024); bus1.in_z = '0;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      cyc = 0;
      while (!bus1.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
      check("l1_latency", cyc, 3);
      for (int n = 0; n < NN; n++) begin
         cyc = 0;
         while (!bus1.out_valid && cyc < 50) begin @(negedge clk); cyc++; end
         check($sformatf("l1_data_n%0d", n), bus1.out_data, model_k(768, 1024, 0, 0, 0, 0, 1'b1));
         check($sformatf("l1_idx_n%0d", n), bus1.out_idx, n);
         check($sformatf("l1_last_n%0d", n), bus1.out_last, (n == NN - 1));
         @(negedge clk);
      end
      check("l1_in_ready_end", bus1.in_ready, 1);

      // Load all nodes, run a row and attempt writes while busy
      for (int i = 0; i < NN; i++) write_node(i, tx[i], ty[i], tz[i]);
      start_query(300, -400, 1200, 1'b0, 0, 0, 0, 0);
      check("row2_busy", busy2, 1);
      bus2.node_wr_en   = 1'b1;
      bus2.node_wr_addr = 3'(2);
      bus2.node_wr_x    = 16'(1);
      bus2.node_wr_y    = 16'(2);
      bus2.node_wr_z    = 16'(3);
      repeat (3) @(negedge clk);
      bus2.node_wr_en = 1'b0;
      collect(NN, -1, lat);
      check("row2_in_ready", bus2.in_ready, 1);

      // Same-edge write of a saturating node, backpressure on sample 3
      start_query(32767, 32767, 32767, 1'b1, 0, -32768, -32768, -32768);
      collect(NN, 3, lat);
      check("row3_in_ready", bus2.in_ready, 1);
      check("row3_busy", busy2, 0);

      // Reset during SQRT of node 3
      start_query(1000, -2000, 300, 1'b0, 0, 0, 0, 0);
      collect(3, -1, lat);
      repeat (5) @(negedge clk);
      check("pre_rst_busy", busy2, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_out_valid", bus2.out_valid, 0);
      check("mid_rst_in_ready", bus2.in_ready, 1);
      check("mid_rst_busy", busy2, 0);
      rst = 1'b0;
      sb.delete();
      for (int i = 0; i < NN; i++) begin
         mem_x[i] = 0; mem_y[i] = 0; mem_z[i] = 0;
      end
      repeat (25) @(negedge clk);
      check("post_rst_no_output", bus2.out_valid, 0);
      start_query(0, 0, 0, 1'b0, 0, 0, 0, 0);
      collect(NN, -1, lat);
      check("row5_in_ready", bus2.in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
